// File: rtl/bram_rd_pkg.sv
// Shared FSM encodings and buffer sizing for the BRAM stream reader.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream with a last marker; master drives data, slave drives ready.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/dpram.sv
// Dual-port RAM with a 1-cycle registered read on each port.
module dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en_a) begin
            if (we_a) mem[addr_a] <= din_a;
            dout_a <= mem[addr_a];
        end
        if (en_b) begin
            if (we_b) mem[addr_b] <= din_b;
            dout_b <= mem[addr_b];
        end
    end
endmodule

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO; the head register drives the stream data directly.
module skid_fifo2 import bram_rd_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    assign dout = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // pop implies count>0; a full FIFO cannot see a push
                    if (count == 2'd1) head <= din;
                    else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// Reads length words from a dpram port starting at base_addr (wrapping) and
// streams them out with valid/ready and a last marker.
//
// state | meaning
// IDLE  | waiting for start; only state that samples start
// READ  | RAM reads still being issued
// DRAIN | all reads issued; emptying read pipeline and FIFO
module bram_stream_reader import bram_rd_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    bram_stream_reader_if.master  m
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   beat_cnt;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  inflight;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  issue;

    skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (ram_dout),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    assign m.valid   = (fifo_count != 2'd0);
    assign m.data    = fifo_head;
    assign m.last    = m.valid && (beat_cnt == last_idx);
    assign pop       = m.valid && m.ready;
    assign busy      = (state != ST_IDLE);

    // a beat leaving this cycle frees a slot for a new read
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue     = (state == ST_READ) && (remaining != '0) &&
                       (occupancy < 3'(FIFO_DEPTH) + {2'b00, pop});
    assign ram_en    = issue;
    assign ram_addr  = issue ? addr_cnt : ram_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_cnt   <= '0;
            ram_addr_q <= '0;
            remaining  <= '0;
            beat_cnt   <= '0;
            last_idx   <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                addr_cnt   <= addr_cnt + ADDR_ONE;
                ram_addr_q <= addr_cnt;
                remaining  <= remaining - CNT_ONE;
            end
            if (pop) beat_cnt <= beat_cnt + CNT_ONE;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ST_READ;
                            addr_cnt  <= base_addr;
                            remaining <= length;
                            beat_cnt  <= '0;
                            last_idx  <= length - CNT_ONE;
                        end
                    end
                end
                ST_READ: begin
                    if (issue && remaining == CNT_ONE) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && m.last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side streaming engine for a `dpram` port. On a `start` command it reads `length` consecutive words beginning at `base_addr`, with addresses wrapping modulo the RAM depth. It absorbs the RAM's 1-cycle registered read latency and presents the words on a valid/ready stream with a `last` marker. It sits between a `dpram` port (A or B, write-enable tied low) and any downstream consumer such as a DMA, UART TX or checksum unit.

## Interface
- `DATA_WIDTH`, 32, word width; must match the attached RAM.
- `ADDR_WIDTH`, 8, RAM address width; RAM depth is 2^ADDR_WIDTH.

- `clk`  in  1  single clock; the RAM port is clocked by the same clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  command strobe; sampled only while idle.
- `base_addr`  in  ADDR_WIDTH  first word address.
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- `busy`  out  1  transfer in progress.
- `done`  out  1  1-cycle completion pulse.
- `ram_en`  out  1  RAM port enable; RAM write-enable is tied 0 externally.
- `ram_addr`  out  ADDR_WIDTH  RAM port address.
- `ram_dout`  in  DATA_WIDTH  RAM read data, valid 1 cycle after `ram_en`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  consumer accepts the current beat.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  marks the final beat of the transfer.

## Operation
- States:
  - IDLE: the only state that samples `start`.
  - READ: reads are still being issued.
  - DRAIN: all reads issued; emptying the pipeline and FIFO.
- Transitions:
  - IDLE + `start` + `length`≠0 → READ. Latches `base_addr` into the address counter and `length` into the remaining counter.
  - IDLE + `start` + `length`=0 → `done` pulses next cycle; no reads, no beats; `busy` stays 0.
  - READ → DRAIN when the last read is issued.
  - DRAIN → IDLE on the handshake of the `m_last` beat.
- Read issue: `ram_en` = READ & remaining≠0 & (fifo_count + inflight − pop < 2).
  - On issue: address increments mod 2^ADDR_WIDTH and remaining decrements.
  - `inflight` is set on issue and cleared the following cycle.
- Return path: while `inflight` is set, `ram_dout` is pushed into a 2-entry FIFO; the FIFO head drives `m_data`.
- `m_last` = `m_valid` & (head is beat number `length`−1). A beat counter tracks this.
- Stream rule: `m_data` and `m_last` hold stable while `m_valid` & !`m_ready`.
- `start` while `busy` is ignored.
- Throughput: 1 beat/cycle with `m_ready` held high. At most 1 read in flight and at most 2 buffered words; no overflow is possible.
- Reset: IDLE. Reset values:
  - `busy`, `done`, `ram_en`, `m_valid`, `m_last` = 0.
  - `ram_addr`, `m_data` = 0.
  - FIFO, `inflight` and all counters cleared.
- Reset mid-transfer discards in-flight data; the next `start` behaves normally.

## Timing
- `start` is sampled at the end of cycle 0.
  - Cycle 1: `busy`=1, `ram_en`=1, `ram_addr`=base.
  - Cycle 2: `ram_dout` valid; pushed into the FIFO at the end of the cycle.
  - Cycle 3: first `m_valid`.
- With `m_ready`=1 throughout: beat k appears in cycle 3+k; last beat in cycle 2+`length`.
- `done`=1 and `busy`=0 in the cycle after the last-beat handshake. A new `start` may be sampled in that same cycle.
- `ram_addr` is driven only while `ram_en`=1; otherwise it holds its last value.

## Structure
- Shared package/include `bram_rd_pkg`: state encodings (IDLE=0, READ=1, DRAIN=2) and FIFO depth constant (2).
- Sub-module `skid_fifo2` holds the 2-entry synchronous FIFO with push/pop and count.
- The top level holds the FSM, counters and issue logic.
- The bench instantiates `bram_stream_reader` with a `dpram`, using port B for preload.

## Test plan
- Aligned run: mem[i]=3i, base=0x10, length=4, `m_ready`=1.
  - Beats 0x30, 0x33, 0x36, 0x39 in cycles 3–6; `m_last` on 0x39.
  - `done` in cycle 7.
- Wrap: base=0xFE, length=4.
  - `ram_addr` sequence FE, FF, 00, 01.
  - Data order preserved; `m_last` on the word read from 01.
- Backpressure: length=8; `m_ready` low for 5 cycles mid-run, then random toggling.
  - Never more than 2 words buffered plus 1 in flight.
  - All 8 words arrive in order, stable while stalled.
- Edge lengths:
  - length=0: `done` in cycle 1; no `ram_en`, no `m_valid`.
  - length=256: all 256 words in 256 consecutive beats with `m_ready`=1.
- Start while busy: a second `start` during a transfer is ignored. Only the first transfer's beats appear, and there is a single `done`.
- Reset mid-stream: assert `rst_n`=0 during beat 2.
  - All outputs are 0 in the next cycle.
  - A following `start` with base=0, length=2 streams mem[0] and mem[1] correctly.
